// File: rtl/rca_seq_ctrl.sv
// Nibble-serial wide adder/subtractor built around one 4-bit ripple-carry adder.
// Define RCA_SEQ_SUB_EN to honour the op input (A - B); otherwise the block is add-only.

module rca (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);
   logic [4:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[4];
endmodule

module rca_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic [1:0]           dbg_state
);
   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready is high only in IDLE, out_valid only in DONE.

   logic [1:0]      r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_sum;
   logic [IDXW-1:0] r_idx;
   logic            r_carry;
   logic            r_cout;
   logic            r_ovf;

   logic            w_op_eff;
   logic [W-1:0]    w_b_eff;
   logic [W-1:0]    w_a_sh;
   logic [W-1:0]    w_b_sh;
   logic [3:0]      w_a_nib;
   logic [3:0]      w_b_nib;
   logic [3:0]      w_rca_sum;
   logic            w_rca_cout;

`ifdef RCA_SEQ_SUB_EN
   // B is stored already inverted so the RUN datapath needs no op mux.
   assign w_op_eff = op;
   assign w_b_eff  = op ? ~b : b;
`else
   logic w_unused_op;
   assign w_unused_op = op;
   assign w_op_eff    = 1'b0;
   assign w_b_eff     = b;
`endif

   assign w_a_sh  = r_a >> {r_idx, 2'b00};
   assign w_b_sh  = r_b >> {r_idx, 2'b00};
   assign w_a_nib = w_a_sh[3:0];
   assign w_b_nib = w_b_sh[3:0];

   rca u_rca (
      .i_a    (w_a_nib),
      .i_b    (w_b_nib),
      .i_cin  (r_carry),
      .o_sum  (w_rca_sum),
      .o_cout (w_rca_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= w_b_eff;
                  r_carry <= w_op_eff;
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (r_idx == IDXW'(i)) r_sum[4*i +: 4] <= w_rca_sum;
               end
               r_carry <= w_rca_cout;
               if (r_idx == IDX_LAST) begin
                  r_cout  <= w_rca_cout;
                  // Carry into the MSB xor carry out of it, with the MSB carry-in recovered from the sum bit.
                  r_ovf   <= r_a[W-1] ^ r_b[W-1] ^ w_rca_sum[3] ^ w_rca_cout;
                  r_idx   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: NIBBLES=4 instance plus a NIBBLES=1 instance, checked against an arithmetic model.

module tb_rca_seq_ctrl;
   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, op, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   logic [1:0]  dbg_state;

   logic        n1_in_valid, n1_in_ready, n1_op, n1_out_valid, n1_out_ready, n1_cout, n1_ovf;
   logic [3:0]  n1_a, n1_b, n1_sum;
   logic [1:0]  n1_dbg_state;

   int checks;
   int failures;

   // {cout, ovf, sum}
   logic [17:0] exp_q[$];

   rca_seq_ctrl #(.NIBBLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .dbg_state(dbg_state)
   );

   rca_seq_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
      .a(n1_a), .b(n1_b), .op(n1_op), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
      .sum(n1_sum), .cout(n1_cout), .ovf(n1_ovf), .dbg_state(n1_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain modular arithmetic at width w.
   function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                         input logic opv);
      logic        eff;
      int unsigned msk, ai, bi, s, c, o;
`ifdef RCA_SEQ_SUB_EN
      eff = opv;
`else
      eff = 1'b0;
`endif
      msk = (32'd1 << w) - 1;
      ai  = av & msk;
      bi  = bv & msk;
      if (eff) begin
         s = (ai - bi) & msk;
         c = (ai >= bi) ? 1 : 0;
         o = (ai[w-1] != bi[w-1] && s[w-1] != ai[w-1]) ? 1 : 0;
      end else begin
         s = (ai + bi) & msk;
         c = ((ai + bi) > msk) ? 1 : 0;
         o = (ai[w-1] == bi[w-1] && s[w-1] != ai[w-1]) ? 1 : 0;
      end
      return {c[0], o[0], s[15:0]};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
      n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_a = '0; n1_b = '0; n1_op = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Drive one operation on the 4-nibble DUT, check latency and result, hold
   // out_ready low for 'hold' cycles checking stability, then release.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic opv, input int hold);
      logic [17:0] e;
      int lat;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL in_ready_before_accept got=%b want=1", in_ready);
      end
      in_valid = 1'b1; a = av; b = bv; op = opv;
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid === 1'b1) break;
      end
      checks++;
      if (lat != 4 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL latency got=%0d out_valid=%b want=4", lat, out_valid);
      end
      e = exp_q.pop_front();
      checks++;
      if ({cout, ovf, sum} !== e) begin
         failures++;
         $display("FAIL result a=%h b=%h op=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                  av, bv, opv, sum, cout, ovf, e[15:0], e[17], e[16]);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if ({cout, ovf, sum} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable cyc=%0d got sum=%h cout=%b ovf=%b ov=%b ir=%b want sum=%h ov=1 ir=0",
                     i, sum, cout, ovf, out_valid, in_ready, e[15:0]);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL release_to_idle got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got ir=%b ov=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
                  in_ready, out_valid, sum, cout, ovf);
      end
   endtask

   task automatic test_add_directed();
      exp_q.push_back({1'b0, 1'b0, 16'h2233}); run_op(16'h1234, 16'h0FFF, 1'b0, 0);
      exp_q.push_back({1'b1, 1'b0, 16'h0000}); run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      exp_q.push_back({1'b0, 1'b1, 16'h8000}); run_op(16'h7FFF, 16'h0001, 1'b0, 0);
   endtask

   task automatic test_sub_directed();
`ifdef RCA_SEQ_SUB_EN
      exp_q.push_back({1'b0, 1'b0, 16'hFFFE}); run_op(16'h0005, 16'h0007, 1'b1, 0);
      exp_q.push_back({1'b1, 1'b1, 16'h7FFF}); run_op(16'h8000, 16'h0001, 1'b1, 0);
`else
      exp_q.push_back({1'b0, 1'b0, 16'h000C}); run_op(16'h0005, 16'h0007, 1'b1, 0);
      exp_q.push_back({1'b0, 1'b0, 16'h8001}); run_op(16'h8000, 16'h0001, 1'b1, 0);
`endif
   endtask

   task automatic test_random();
      logic [15:0] av, bv;
      logic        opv;
      for (int n = 0; n < 24; n++) begin
         av  = 16'($urandom);
         bv  = 16'($urandom);
         opv = 1'($urandom);
         if (n % 6 == 0) av = 16'h8000 | av;
         exp_q.push_back(model(16, av, bv, opv));
         run_op(av, bv, opv, $urandom_range(0, 3));
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] e;
      int lat;
      exp_q.push_back(model(16, 16'h4321, 16'h1111, 1'b0));
      run_op(16'h4321, 16'h1111, 1'b0, 10);
      // second op: extra in_valid held through a long DONE window must be ignored
      e = model(16, 16'h0F0F, 16'h0101, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; op = 1'b0;
      @(posedge clk);
      #1;
      a = 16'hAAAA; b = 16'h5555;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid === 1'b1) break;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({cout, ovf, sum} !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_ignore_valid cyc=%0d got sum=%h ir=%b ov=%b want sum=%h ir=0 ov=1",
                     i, sum, in_ready, out_valid, e[15:0]);
         end
      end
      a = 16'h0123; b = 16'h0456;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_idle_next_edge got ir=%b want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept_following got ir=%b want 0", in_ready);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      e = model(16, 16'h0123, 16'h0456, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || {cout, ovf, sum} !== e) begin
         failures++;
         $display("FAIL bp_followup got ov=%b sum=%h want ov=1 sum=%h", out_valid, sum, e[15:0]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 16'h0 || in_ready !== 1'b1 || cout !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_run got ov=%b sum=%h ir=%b cout=%b ovf=%b want 0 0000 1 0 0",
                  out_valid, sum, in_ready, cout, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 16'h0002});
      run_op(16'h0001, 16'h0001, 1'b0, 0);
   endtask

   task automatic test_nibbles1();
      logic [3:0]  av, bv;
      logic        opv;
      logic [17:0] e;
      int lat;
      for (int n = 0; n < 8; n++) begin
         if (n == 0) begin
            av = 4'h9; bv = 4'h8; opv = 1'b0;
         end else begin
            av = 4'($urandom); bv = 4'($urandom); opv = 1'($urandom);
         end
         e = model(4, {12'h0, av}, {12'h0, bv}, opv);
         if (n == 0) e = {1'b1, 1'b1, 16'h0001};
         @(negedge clk);
         n1_in_valid = 1'b1; n1_a = av; n1_b = bv; n1_op = opv;
         @(posedge clk);
         #1;
         n1_in_valid = 1'b0;
         lat = 0;
         while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (n1_out_valid === 1'b1) break;
         end
         checks++;
         if (lat != 1 || n1_out_valid !== 1'b1 || {n1_cout, n1_ovf, n1_sum} !== {e[17:16], e[3:0]}) begin
            failures++;
            $display("FAIL nib1 a=%h b=%h op=%b lat=%0d got sum=%h cout=%b ovf=%b want lat=1 sum=%h cout=%b ovf=%b",
                     av, bv, opv, lat, n1_sum, n1_cout, n1_ovf, e[3:0], e[17], e[16]);
         end
         n1_out_ready = 1'b1;
         @(posedge clk);
         #1;
         n1_out_ready = 1'b0;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add_directed();
      test_sub_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_nibbles1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Multi-cycle sequencer that performs wide addition (and optionally subtraction) by time-multiplexing a single instance of the team's 4-bit ripple-carry adder `rca`, one nibble per clock, least-significant nibble first. It sits between an operand source (switch/register front end) and the result consumer (7-segment driver path), using a valid/ready handshake on both sides. One operation is in flight at a time.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair presented.
- `in_ready`  out  1  block can accept operands; equals (state == IDLE).
- `a`  in  W  operand A, sampled on accept.
- `b`  in  W  operand B, sampled on accept.
- `op`  in  1  0 = add, 1 = subtract (A − B); sampled on accept; ignored without `RCA_SEQ_SUB_EN`.
- `out_valid`  out  1  result registers hold a completed result.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  W  result, registered.
- `cout`  out  1  carry out of MSB (for subtraction: 1 = no borrow).
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: `in_ready`=1. On `in_valid` at a rising edge: capture `a`, `b`, effective op; carry register ← effective op (1 for subtract, else 0); nibble index ← 0; go RUN.
- RUN: `rca` inputs = A nibble[idx], B' nibble[idx], carry register, where B' = ~B when effective op = 1, else B. Each edge: `sum` nibble[idx] ← rca sum; carry register ← rca cout; idx ← idx+1. On the edge where idx == NIBBLES−1: also load `cout` ← rca cout, `ovf` ← A[W−1] ^ B'[W−1] ^ rca sum[3] ^ rca cout; go DONE.
- DONE: `out_valid`=1; `sum`, `cout`, `ovf` held stable. On `out_ready` at an edge: go IDLE. `in_ready` is 0 in DONE; no same-cycle restart.
- `in_valid` outside IDLE is ignored; `a`/`b`/`op` changes after accept have no effect.
- `sum` nibbles update during RUN; contents are defined only while `out_valid`=1.
- Arithmetic modulo 2^W; no saturation. idx counter width ceil(log2(NIBBLES)), minimum 1 bit.

## Timing
- Reset (async assert, any state, including mid-RUN): state IDLE, `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0, idx=0, carry=0; `in_ready`=1 once state is IDLE. Deassertion is treated as synchronous to `clk` by the system.
- Latency: accept on edge T → `out_valid` rises after edge T+NIBBLES (NIBBLES=4: 4 cycles).
- Throughput: one operation per NIBBLES+2 cycles with `out_ready` held high (accept, NIBBLES RUN cycles, one DONE cycle, back to IDLE).
- `out_valid` remains high indefinitely while `out_ready`=0.
- Critical path: one 4-bit ripple plus carry-register setup; no combinational path from `in_valid` or `out_ready` to any output other than via state.

## Configuration
- `RCA_SEQ_SUB_EN` defined: `op` honoured; subtract inverts B nibbles and seeds carry with 1; `cout`=0 signals borrow.
- Not defined: `op` port present but ignored; effective op forced to 0; no B inversion logic synthesised; block is add-only.

## Test plan
- NIBBLES=4, add 0x1234 + 0x0FFF -> after 4 cycles `out_valid`=1, `sum`=0x2233, `cout`=0, `ovf`=0.
- Add 0xFFFF + 0x0001 -> `sum`=0x0000, `cout`=1, `ovf`=0; add 0x7FFF + 0x0001 -> `sum`=0x8000, `cout`=0, `ovf`=1.
- With `RCA_SEQ_SUB_EN`, op=1: 0x0005 − 0x0007 -> `sum`=0xFFFE, `cout`=0, `ovf`=0; 0x8000 − 0x0001 -> `sum`=0x7FFF, `cout`=1, `ovf`=1. Without macro, same stimulus with op=1 -> 0x0005+0x0007 = 0x000C.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> `sum`/`cout`/`ovf` stable, `in_ready`=0, a second `in_valid` ignored; raise `out_ready` -> IDLE next edge, next operand accepted following edge.
- Reset mid-RUN: assert `rst_n`=0 after 2 RUN cycles -> immediately `out_valid`=0, `sum`=0, `in_ready`=1; after release, 0x0001+0x0001 yields 0x0002 in 4 cycles.
- NIBBLES=1: 0x9 + 0x8 -> `out_valid` after 1 cycle, `sum`=0x1, `cout`=1, `ovf`=1.
